// File: rtl/pc_gen_bpu.sv
// pc_gen_bpu -- registered next-PC generator with a direct-mapped BTB.
//
// Drives the IF fetch address. Each BTB entry holds a valid bit, a tag, a
// target and a 2-bit saturating counter. The fetch PC is looked up in the BTB
// combinationally. EX-stage control transfers are resolved combinationally.
// On a mispredict the pipe is flushed and the PC is redirected. The resolved
// outcome then trains the BTB.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i             hold the PC (IF/ID stall); a mispredict overrides it
//   pc_o                current fetch PC
//   pred_taken_o        prediction for pc_o
//   pred_target_o       predicted next PC for pc_o
//   ex_*_i              resolution inputs from the EX stage
//   flush_o             squash IF/ID (combinational, equals mispredict)
//   branch_cnt_o        resolved control-transfer count
//   mispred_cnt_o       mispredict count
module pc_gen_bpu #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16,
  parameter bit              PREDICT_EN  = 1'b1,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  input  logic             ex_valid_i,
  input  logic             ex_jal_i,
  input  logic             ex_jalr_i,
  input  logic             ex_branch_i,
  input  logic             ex_cond_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_pc_imm_i,
  input  logic [XLEN-1:0]  ex_rs1_imm_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pred_target_i,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             btb_valid_q [BTB_ENTRIES];
  logic             btb_valid_d [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_d   [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_q   [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_d   [BTB_ENTRIES];
  logic [1:0]       btb_ctr_q   [BTB_ENTRIES];
  logic [1:0]       btb_ctr_d   [BTB_ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Fetch-side lookup: reads pre-update contents, no bypass from EX training.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[XLEN-1:IDX_W+2];
  assign lk_hit = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);

  assign pc_o          = pc_q;
  assign pred_taken_o  = PREDICT_EN && lk_hit && btb_ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? btb_tgt_q[lk_idx] : pc_q + FOUR;

  // EX-stage resolution.
  logic            ctl, act_taken, mispred;
  logic [XLEN-1:0] act_tgt, act_next;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    ctl       = ex_valid_i && (ex_jal_i || ex_jalr_i || ex_branch_i);
    act_taken = ex_jal_i || ex_jalr_i || (ex_branch_i && ex_cond_i);
    act_tgt   = ex_pc_imm_i;
    if (ex_jalr_i && !ex_jal_i) act_tgt = ex_rs1_imm_i & ~XLEN'(1);
    act_next  = act_taken ? act_tgt : ex_pc_i + FOUR;
    mispred   = ctl && ((act_taken != ex_pred_taken_i) ||
                        (act_taken && (act_tgt != ex_pred_target_i)));
  end

  assign flush_o = mispred;

  // Next PC: a redirect beats a stall.
  always_comb begin
    pc_d = pc_q;
    if (mispred)       pc_d = act_next;
    else if (!stall_i) pc_d = pred_target_o;
  end

  // BTB training, indexed by the EX PC.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign up_idx = ex_pc_i[IDX_W+1:2];
  assign up_tag = ex_pc_i[XLEN-1:IDX_W+2];
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    btb_ctr_d   = btb_ctr_q;
    if (ctl && PREDICT_EN) begin
      if (up_hit) begin
        if (act_taken) begin
          if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'b01;
          btb_tgt_d[up_idx] = act_tgt;
        end else if (btb_ctr_q[up_idx] != 2'b00) begin
          btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'b01;
        end
      end else if (act_taken) begin
        // Miss on a taken transfer: allocate, evicting any alias, weakly taken.
        btb_valid_d[up_idx] = 1'b1;
        btb_tag_d[up_idx]   = up_tag;
        btb_tgt_d[up_idx]   = act_tgt;
        btb_ctr_d[up_idx]   = 2'b10;
      end
    end
  end

  // Performance counters wrap naturally and ignore stalls.
  always_comb begin
    branch_cnt_d  = branch_cnt_q + CNT_W'(ctl);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(mispred);
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      // NOTE: the BTB is built from flops and must be reset, because a stale
      // valid bit would predict a bogus target straight out of reset.
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        btb_ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q          <= pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      btb_valid_q   <= btb_valid_d;
      btb_tag_q     <= btb_tag_d;
      btb_tgt_q     <= btb_tgt_d;
      btb_ctr_q     <= btb_ctr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen_bpu.sv
// Testbench for pc_gen_bpu. Three instances run side by side:
//   0: 16 entries, prediction on
//   1: 4 entries, prediction on (aliasing)
//   2: 16 entries, prediction off
// A behavioural model tracks each instance. The model keeps BTB entries as
// whole word addresses and counters as plain integers. The stimulus consists
// of directed scenarios followed by random traffic.
module tb_pc_gen_bpu;

  localparam int NI = 3;

  typedef struct packed {
    logic        valid, jal, jalr, branch, cond;
    logic [31:0] pc, pc_imm, rs1_imm;
    logic        pred_taken;
    logic [31:0] pred_target;
  } ex_t;

  logic        clk, rst_n;
  ex_t         ex            [NI];
  logic        stall         [NI];
  logic [31:0] pc_o          [NI];
  logic        pred_taken_o  [NI];
  logic [31:0] pred_target_o [NI];
  logic        flush_o       [NI];
  logic [31:0] branch_cnt_o  [NI];
  logic [31:0] mispred_cnt_o [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pc_gen_bpu #(
      .XLEN(32), .RESET_PC(32'h0), .BTB_ENTRIES(g == 1 ? 4 : 16),
      .PREDICT_EN(g != 2), .CNT_W(32)
    ) dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall[g]),
      .pc_o(pc_o[g]), .pred_taken_o(pred_taken_o[g]), .pred_target_o(pred_target_o[g]),
      .ex_valid_i(ex[g].valid), .ex_jal_i(ex[g].jal), .ex_jalr_i(ex[g].jalr),
      .ex_branch_i(ex[g].branch), .ex_cond_i(ex[g].cond), .ex_pc_i(ex[g].pc),
      .ex_pc_imm_i(ex[g].pc_imm), .ex_rs1_imm_i(ex[g].rs1_imm),
      .ex_pred_taken_i(ex[g].pred_taken), .ex_pred_target_i(ex[g].pred_target),
      .flush_o(flush_o[g]), .branch_cnt_o(branch_cnt_o[g]), .mispred_cnt_o(mispred_cnt_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_pc   [NI];
  bit          m_v    [NI][16];
  logic [31:0] m_addr [NI][16];
  logic [31:0] m_tgt  [NI][16];
  int          m_ctr  [NI][16];
  logic [31:0] m_bc   [NI];
  logic [31:0] m_mc   [NI];

  function automatic int ent_of(int m);
    return (m == 1) ? 4 : 16;
  endfunction

  function automatic bit pen_of(int m);
    return m != 2;
  endfunction

  function automatic int m_idx(int m, logic [31:0] a);
    return int'(a[31:2]) % ent_of(m);
  endfunction

  function automatic void m_reset(int m);
    m_pc[m] = 32'h0;
    m_bc[m] = 32'h0;
    m_mc[m] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_v[m][i] = 1'b0;
      m_addr[m][i] = 32'h0;
      m_tgt[m][i] = 32'h0;
      m_ctr[m][i] = 1;
    end
  endfunction

  function automatic void m_lookup(int m, logic [31:0] a, output bit tk, output logic [31:0] tg);
    int i = m_idx(m, a);
    tk = pen_of(m) && m_v[m][i] && (m_addr[m][i][31:2] == a[31:2]) && (m_ctr[m][i] >= 2);
    tg = tk ? m_tgt[m][i] : a + 32'd4;
  endfunction

  function automatic void m_resolve(int m, output bit ctl, output bit tk, output bit mp,
                                    output logic [31:0] tgt, output logic [31:0] nxt);
    ex_t e = ex[m];
    ctl = e.valid && (e.jal || e.jalr || e.branch);
    tk  = e.jal || e.jalr || (e.branch && e.cond);
    if (e.jal)       tgt = e.pc_imm;
    else if (e.jalr) tgt = {e.rs1_imm[31:1], 1'b0};
    else             tgt = e.pc_imm;
    nxt = tk ? tgt : e.pc + 32'd4;
    mp  = ctl && ((tk != e.pred_taken) || (tk && (tgt != e.pred_target)));
  endfunction

  function automatic void m_tick(int m);
    bit tk, ctl, atk, mp;
    logic [31:0] tg, atg, nxt;
    int i;
    m_lookup(m, m_pc[m], tk, tg);
    m_resolve(m, ctl, atk, mp, atg, nxt);
    if (mp)             m_pc[m] = nxt;
    else if (!stall[m]) m_pc[m] = tg;
    if (ctl && pen_of(m)) begin
      i = m_idx(m, ex[m].pc);
      if (m_v[m][i] && (m_addr[m][i][31:2] == ex[m].pc[31:2])) begin
        if (atk) begin
          m_ctr[m][i] = (m_ctr[m][i] < 3) ? m_ctr[m][i] + 1 : 3;
          m_tgt[m][i] = atg;
        end else begin
          m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
        end
      end else if (atk) begin
        m_v[m][i] = 1'b1;
        m_addr[m][i] = ex[m].pc;
        m_tgt[m][i] = atg;
        m_ctr[m][i] = 2;
      end
    end
    if (ctl) m_bc[m] = m_bc[m] + 32'd1;
    if (mp)  m_mc[m] = m_mc[m] + 32'd1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit tk, ctl, atk, mp;
    logic [31:0] tg, atg, nxt;
    for (int m = 0; m < NI; m++) begin
      m_lookup(m, m_pc[m], tk, tg);
      m_resolve(m, ctl, atk, mp, atg, nxt);
      check($sformatf("pc[%0d]", m), pc_o[m], m_pc[m]);
      check($sformatf("pred_taken[%0d]", m), 32'(pred_taken_o[m]), 32'(tk));
      check($sformatf("pred_target[%0d]", m), pred_target_o[m], tg);
      check($sformatf("flush[%0d]", m), 32'(flush_o[m]), 32'(mp));
      check($sformatf("branch_cnt[%0d]", m), branch_cnt_o[m], m_bc[m]);
      check($sformatf("mispred_cnt[%0d]", m), mispred_cnt_o[m], m_mc[m]);
    end
  endtask

  task automatic sample();
    #1 compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < NI; m++) begin
      if (!rst_n) m_reset(m);
      else        m_tick(m);
    end
    @(negedge clk);
  endtask

  task automatic clear_all();
    for (int m = 0; m < NI; m++) begin
      ex[m] = '0;
      stall[m] = 1'b0;
    end
  endtask

  // kind: 1 branch, 2 JAL, 3 JALR. use_pred takes the model's own BTB
  // prediction for the EX PC, otherwise the instruction was predicted pc+4.
  task automatic drive_ex(input int m, input int kind, input logic [31:0] pc,
                          input logic [31:0] pc_imm, input logic [31:0] rs1,
                          input bit cond, input bit use_pred);
    bit tk;
    logic [31:0] tg;
    ex[m] = '0;
    ex[m].valid = 1'b1;
    ex[m].branch = (kind == 1);
    ex[m].jal = (kind == 2);
    ex[m].jalr = (kind == 3);
    ex[m].pc = pc;
    ex[m].pc_imm = pc_imm;
    ex[m].rs1_imm = rs1;
    ex[m].cond = cond;
    if (use_pred) m_lookup(m, pc, tk, tg);
    else begin
      tk = 1'b0;
      tg = pc + 32'd4;
    end
    ex[m].pred_taken = tk;
    ex[m].pred_target = tg;
  endtask

  task automatic randomize_inputs();
    bit tk;
    logic [31:0] tg;
    int r;
    for (int m = 0; m < NI; m++) begin
      r = int'($urandom_range(0, 7));
      ex[m] = '0;
      stall[m] = ($urandom_range(0, 3) == 0);
      ex[m].pc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 15)) << 2;
      ex[m].pc_imm = 32'($urandom_range(0, 15)) << 2;
      ex[m].rs1_imm = 32'($urandom_range(0, 63));
      ex[m].cond = 1'($urandom_range(0, 1));
      if (r <= 1) begin
        ex[m].valid = 1'b0;
        ex[m].jal = 1'($urandom_range(0, 1));
        ex[m].jalr = 1'($urandom_range(0, 1));
        ex[m].branch = 1'($urandom_range(0, 1));
      end else begin
        ex[m].valid = 1'b1;
        ex[m].branch = (r <= 4);
        ex[m].jal = (r == 5);
        ex[m].jalr = (r == 6);
      end
      if ($urandom_range(0, 1) == 1) begin
        m_lookup(m, ex[m].pc, tk, tg);
        ex[m].pred_taken = tk;
        ex[m].pred_target = tg;
      end else begin
        ex[m].pred_taken = 1'($urandom_range(0, 1));
        ex[m].pred_target = ($urandom_range(0, 1) == 1) ? ex[m].pc_imm : ex[m].pc + 32'd4;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_all();
    rst_n = 1'b0;
    for (int m = 0; m < NI; m++) m_reset(m);
    sample();
    check("reset_pc", pc_o[0], 32'h0);
    check("reset_branch_cnt", branch_cnt_o[0], 32'h0);
    tick();
    rst_n = 1'b1;

    // Idle fetch walks sequentially.
    for (int i = 0; i < 3; i++) begin
      sample();
      check("seq_pc", pc_o[0], 32'(i * 4));
      check("seq_pred_taken", 32'(pred_taken_o[0]), 32'h0);
      check("seq_flush", 32'(flush_o[0]), 32'h0);
      tick();
    end

    // Branch at 0x10 taken to 0x40, four iterations.
    for (int it = 0; it < 4; it++) begin
      drive_ex(0, 1, 32'h10, 32'h40, 32'h0, 1'b1, 1'b1);
      sample();
      check("br_taken_flush", 32'(flush_o[0]), (it == 0) ? 32'h1 : 32'h0);
      tick();
      if (it == 0) check("br_redirect_pc", pc_o[0], 32'h40);
    end
    clear_all();
    sample();
    check("br_branch_cnt", branch_cnt_o[0], 32'd4);
    check("br_mispred_cnt", mispred_cnt_o[0], 32'd1);
    tick();

    // Redirect fetch to 0x10 to see the trained prediction.
    drive_ex(0, 2, 32'h100, 32'h10, 32'h0, 1'b0, 1'b0);
    sample();
    tick();
    clear_all();
    sample();
    check("hit_pc", pc_o[0], 32'h10);
    check("hit_pred_taken", 32'(pred_taken_o[0]), 32'h1);
    check("hit_pred_target", pred_target_o[0], 32'h40);
    tick();

    // Same branch not taken twice: counter 3 -> 2 -> 1.
    for (int it = 0; it < 2; it++) begin
      drive_ex(0, 1, 32'h10, 32'h40, 32'h0, 1'b0, 1'b1);
      sample();
      check("nt_flush", 32'(flush_o[0]), 32'h1);
      tick();
      check("nt_pc", pc_o[0], 32'h14);
    end
    drive_ex(0, 2, 32'h104, 32'h10, 32'h0, 1'b0, 1'b0);
    sample();
    tick();
    clear_all();
    sample();
    check("weak_pc", pc_o[0], 32'h10);
    check("weak_pred_taken", 32'(pred_taken_o[0]), 32'h0);
    check("weak_pred_target", pred_target_o[0], 32'h14);
    tick();

    // JALR with odd rs1+imm during a stall.
    drive_ex(0, 3, 32'h200, 32'h0, 32'h81, 1'b0, 1'b0);
    stall[0] = 1'b1;
    sample();
    check("jalr_flush", 32'(flush_o[0]), 32'h1);
    tick();
    check("jalr_pc", pc_o[0], 32'h80);
    clear_all();

    // PC wraps past the top of the address space.
    drive_ex(0, 2, 32'h300, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    sample();
    tick();
    clear_all();
    sample();
    check("wrap_top_pc", pc_o[0], 32'hFFFF_FFFC);
    tick();
    sample();
    check("wrap_zero_pc", pc_o[0], 32'h0);
    tick();

    // Aliasing on the 4-entry instance: 0x20 evicts 0x10.
    drive_ex(1, 1, 32'h10, 32'h40, 32'h0, 1'b1, 1'b1);
    sample();
    tick();
    drive_ex(1, 1, 32'h20, 32'h60, 32'h0, 1'b1, 1'b1);
    sample();
    check("alias_flush", 32'(flush_o[1]), 32'h1);
    tick();
    drive_ex(1, 2, 32'h104, 32'h10, 32'h0, 1'b0, 1'b0);
    sample();
    tick();
    clear_all();
    sample();
    check("alias_pc", pc_o[1], 32'h10);
    check("alias_pred_taken", 32'(pred_taken_o[1]), 32'h0);
    check("alias_pred_target", pred_target_o[1], 32'h14);
    tick();
    drive_ex(1, 2, 32'h108, 32'h20, 32'h0, 1'b0, 1'b0);
    sample();
    tick();
    clear_all();
    sample();
    check("alias_keep_taken", 32'(pred_taken_o[1]), 32'h1);
    check("alias_keep_target", pred_target_o[1], 32'h60);
    tick();

    // Prediction disabled: every taken branch flushes.
    for (int it = 0; it < 4; it++) begin
      drive_ex(2, 1, 32'h8, 32'h30, 32'h0, 1'b1, 1'b1);
      sample();
      check("nopred_flush", 32'(flush_o[2]), 32'h1);
      tick();
      check("nopred_pc", pc_o[2], 32'h30);
    end
    clear_all();
    sample();
    check("nopred_mispred_cnt", mispred_cnt_o[2], 32'd4);
    check("nopred_branch_cnt", branch_cnt_o[2], 32'd4);
    tick();
    drive_ex(2, 2, 32'h100, 32'h8, 32'h0, 1'b0, 1'b0);
    sample();
    tick();
    clear_all();
    sample();
    check("nopred_pc8", pc_o[2], 32'h8);
    check("nopred_pred_taken", 32'(pred_taken_o[2]), 32'h0);
    tick();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      randomize_inputs();
      sample();
      tick();
    end

    // Asynchronous reset in the middle of a cycle.
    randomize_inputs();
    #2 rst_n = 1'b0;
    for (int m = 0; m < NI; m++) m_reset(m);
    sample();
    check("midrst_pc", pc_o[0], 32'h0);
    check("midrst_mispred_cnt", mispred_cnt_o[0], 32'h0);
    tick();
    randomize_inputs();
    sample();
    tick();
    rst_n = 1'b1;

    for (int c = 0; c < 150; c++) begin
      randomize_inputs();
      sample();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
